icache_dm: RTL
==============

# icache_dm

Direct-mapped, read-only instruction cache between the hart's instruction-fetch port and the main-memory bus. Fetch hits complete one cycle after the request. A miss refills one full line from memory, one word per handshake beat, in ascending address order. A flush command invalidates every line.

## Interface
Parameters:
- XLEN, 32: address and instruction width.
- LINES, 64: number of cache lines (power of two, at least 2).
- WORDS, 4: 32-bit words per line (power of two, at least 2).

Ports:
- i_clk, in, 1: sole clock.
- i_rst, in, 1: asynchronous, active-low reset.
- i_IC_DataReq, in, 1: fetch request from the hart; held with a stable address until o_IC_MemReady.
- i_IC_Addr, in, XLEN: fetch byte address; bits [1:0] are ignored.
- o_IC_MemReady, out, 1: one-cycle pulse; o_IC_Instr is valid in that cycle.
- o_IC_Instr, out, XLEN: fetched instruction.
- i_IC_Flush, in, 1: one-cycle pulse that invalidates all lines.
- o_MEM_Req, out, 1: refill word request to main memory.
- o_MEM_Addr, out, XLEN: word-aligned refill address.
- i_MEM_Ready, in, 1: memory beat complete; i_MEM_Data is valid in that cycle.
- i_MEM_Data, in, XLEN: refill data.

## Operation
Address split, defaults shown:
- Bits [1:0]: byte offset, ignored.
- Next log2(WORDS) bits (2): word select.
- Next log2(LINES) bits (6): index.
- Remaining bits (22): tag.

FSM states: IDLE, LOOKUP, REFILL, FLUSH.
- IDLE: when i_IC_DataReq=1 and no o_IC_MemReady pulse is being issued this cycle, capture the address and read the tag/data arrays synchronously. Next state is LOOKUP.
- LOOKUP, hit (valid[index]=1 and the tags match):
  - Assert o_IC_MemReady=1 with the selected word.
  - Return to IDLE.
  - IDLE ignores i_IC_DataReq in the cycle carrying the pulse, so the hart can retire before the next request is sampled.
- LOOKUP, miss:
  - Clear valid[index].
  - Clear the beat counter.
  - Go to REFILL.
- REFILL:
  - Drive o_MEM_Req=1 and o_MEM_Addr = {tag, index, beat, 2'b00}.
  - On i_MEM_Ready, write i_MEM_Data into word[beat] and increment beat.
  - On the final beat (beat = WORDS-1), write the tag, set valid[index], and go to LOOKUP. The repeated lookup hits.
- FLUSH: clear every valid bit in one cycle, then go to IDLE.

Flush rules:
- i_IC_Flush sets a pending flag.
- The flush executes from IDLE or LOOKUP with priority over new requests.
- A LOOKUP that is pre-empted by a flush does not pulse o_IC_MemReady. The request is re-examined afterwards.
- A flush during REFILL is deferred until the refill completes. The just-refilled line is then invalidated, and the fetch re-misses.

Valid bits are flops so that flush and reset clear them. Tag and data arrays need no reset.

## Timing
- Reset values: o_IC_MemReady=0, o_IC_Instr=0, o_MEM_Req=0, o_MEM_Addr=0. The FSM is in IDLE, all valid bits are 0, the flush flag is 0 and the beat counter is 0.
- Reset asserted mid-refill: o_MEM_Req drops asynchronously. The partial line stays invalid.
- Hit latency: request sampled in cycle N, o_IC_MemReady pulses in cycle N+1.
- Miss latency with zero-wait memory: request in cycle N.
  - N+1: LOOKUP detects the miss.
  - N+2 to N+1+WORDS: refill beats.
  - N+2+WORDS: LOOKUP hits and o_IC_MemReady pulses.
- Memory handshake:
  - o_MEM_Req and o_MEM_Addr stay stable until i_MEM_Ready is sampled high.
  - o_MEM_Req may stay high across consecutive beats.
  - i_MEM_Ready while o_MEM_Req=0 is ignored.
- The beat counter wraps at WORDS but is never observed past WORDS-1.
- When a request and a flush pulse arrive in the same cycle, the flush runs first.

## Configuration
Macro ARVI_IC_STATS_EN.
- When defined:
  - Two extra output ports, o_IC_Hits and o_IC_Misses (32 bits each).
  - Hits counts cycles in LOOKUP that pulse o_IC_MemReady.
  - Misses counts LOOKUP-to-REFILL transitions.
  - Both counters reset to 0 and wrap modulo 2^32.
  - A lookup pre-empted by flush counts as neither a hit nor a miss.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- The shared defines header holds:
  - Cache geometry defaults.
  - The FSM state encodings (IC_IDLE, IC_LOOKUP, IC_REFILL, IC_FLUSH).
  - The address-field width macros.
- Sub-module icache_mem: the synchronous-read tag array and data array, with a word-granular write port. Valid flops, FSM and counters remain in icache_dm.

## Test plan
- Cold miss: after reset, fetch 0x0000_0000 with memory returning 0xA0,0xA1,0xA2,0xA3 at zero wait.
  - Required: o_MEM_Addr sequence 0x0, 0x4, 0x8, 0xC.
  - Required: o_IC_MemReady at cycle N+6 with o_IC_Instr=0xA0.
- Hit: then fetch 0x0000_000A.
  - Required: o_IC_MemReady in the next cycle with 0xA2.
  - Required: o_MEM_Req stays 0.
- Conflict: fetch 0x0000_0400 (index 0, new tag).
  - Required: miss and refill from 0x400.
  - Required: a following fetch of 0x0 misses again.
- Memory stall: hold i_MEM_Ready=0 for 5 cycles on beat 1.
  - Required: o_MEM_Addr holds 0x4 and o_MEM_Req holds 1.
  - Required: o_IC_MemReady stays 0 until the refill completes.
- Flush mid-refill: pulse i_IC_Flush during beat 2.
  - Required: the refill completes all 4 beats.
  - Required: the line ends invalid and the fetch re-misses.
  - With ARVI_IC_STATS_EN: Misses = 2.
- Reset mid-refill: drive i_rst low asynchronously.
  - Required: o_MEM_Req=0 immediately.
  - Required: after release, fetching the same address misses.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the geometry defaults, the controller state encodings and the address-field widths.
package icache_dm_pkg;

   localparam int IC_XLEN_DEF  = 32;
   localparam int IC_LINES_DEF = 64;
   localparam int IC_WORDS_DEF = 4;

   // Byte offset inside a 32-bit word; fetch addresses ignore these bits
   localparam int IC_BYTE_W = 2;

   typedef enum logic [1:0] {
      IC_IDLE   = 2'd0,
      IC_LOOKUP = 2'd1,
      IC_REFILL = 2'd2,
      IC_FLUSH  = 2'd3
   } ic_state_e;

   function automatic int ic_wsel_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int ic_idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Tag is whatever remains above byte offset, word select and index
   function automatic int ic_tag_w(input int xlen, input int lines, input int words);
      return xlen - IC_BYTE_W - $clog2(lines) - $clog2(words);
   endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-port and memory-bus signal bundle for icache_dm.
// The cache uses the slave modport; the hart/memory side uses the master modport.
interface icache_dm_if
   import icache_dm_pkg::*;
#(
   parameter int XLEN = IC_XLEN_DEF
) ();

   logic            i_IC_DataReq;
   logic [XLEN-1:0] i_IC_Addr;
   logic            o_IC_MemReady;
   logic [XLEN-1:0] o_IC_Instr;
   logic            i_IC_Flush;
   logic            o_MEM_Req;
   logic [XLEN-1:0] o_MEM_Addr;
   logic            i_MEM_Ready;
   logic [XLEN-1:0] i_MEM_Data;

   modport slave (
      input  i_IC_DataReq, i_IC_Addr, i_IC_Flush, i_MEM_Ready, i_MEM_Data,
      output o_IC_MemReady, o_IC_Instr, o_MEM_Req, o_MEM_Addr
   );

   modport master (
      output i_IC_DataReq, i_IC_Addr, i_IC_Flush, i_MEM_Ready, i_MEM_Data,
      input  o_IC_MemReady, o_IC_Instr, o_MEM_Req, o_MEM_Addr
   );

endinterface

// File: rtl/icache_dm_mem.sv
// Tag and data storage for icache_dm: synchronous-read arrays with a word-granular write port.
// Reads are write-first so a lookup issued alongside the last refill beat sees the new line.
module icache_mem
   import icache_dm_pkg::*;
#(
   parameter int LINES  = IC_LINES_DEF,
   parameter int WORDS  = IC_WORDS_DEF,
   parameter int TAG_W  = 22,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(LINES),
   parameter int WSEL_W = $clog2(WORDS)
) (
   input  logic              i_clk,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [WSEL_W-1:0] rd_word,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              data_we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [WSEL_W-1:0] wr_word,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              tag_we,
   input  logic [TAG_W-1:0]  wr_tag
);

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES*WORDS];

   // Tag array: write on line completion, read with forwarding of a same-index write
   always_ff @(posedge i_clk) begin
      if (tag_we) begin
         tag_mem[wr_idx] <= wr_tag;
      end
      rd_tag <= (tag_we && (wr_idx == rd_idx)) ? wr_tag : tag_mem[rd_idx];
   end

   // Data array: one word per refill beat, read with forwarding of a same-word write
   always_ff @(posedge i_clk) begin
      if (data_we) begin
         data_mem[{wr_idx, wr_word}] <= wr_data;
      end
      rd_data <= (data_we && ({wr_idx, wr_word} == {rd_idx, rd_word}))
                 ? wr_data : data_mem[{rd_idx, rd_word}];
   end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the fetch port and main memory.
// Hits answer one cycle after the request; misses refill a whole line word by word.
// Optional hit/miss counters are built when ARVI_IC_STATS_EN is defined.
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int XLEN  = IC_XLEN_DEF,
   parameter int LINES = IC_LINES_DEF,
   parameter int WORDS = IC_WORDS_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   icache_dm_if.slave  bus
`ifdef ARVI_IC_STATS_EN
   ,
   output logic [31:0] o_IC_Hits,
   output logic [31:0] o_IC_Misses
`endif
);

   localparam int WSEL_W  = ic_wsel_w(WORDS);
   localparam int IDX_W   = ic_idx_w(LINES);
   localparam int TAG_W   = ic_tag_w(XLEN, LINES, WORDS);
   localparam int WSEL_LO = IC_BYTE_W;
   localparam int IDX_LO  = WSEL_LO + WSEL_W;
   localparam int TAG_LO  = IDX_LO + IDX_W;

   ic_state_e         state;
   ic_state_e         state_nxt;
   logic [TAG_W-1:0]  tag_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WSEL_W-1:0] wsel_q;
   logic [WSEL_W-1:0] beat;
   logic [LINES-1:0]  valid;
   logic              flush_pend;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WSEL_W-1:0] req_wsel;
   logic [TAG_W-1:0]  rd_tag;
   logic [XLEN-1:0]   rd_data;
   logic [IDX_W-1:0]  rd_idx;
   logic [WSEL_W-1:0] rd_word;

   logic flush_req;
   logic hit;
   logic last_beat;
   logic beat_done;
   logic capture;
   logic ready;
   logic miss;
   logic unused_byte_off;

   assign req_wsel = bus.i_IC_Addr[WSEL_LO +: WSEL_W];
   assign req_idx  = bus.i_IC_Addr[IDX_LO +: IDX_W];
   assign req_tag  = bus.i_IC_Addr[TAG_LO +: TAG_W];
   assign unused_byte_off = ^bus.i_IC_Addr[IC_BYTE_W-1:0];

   // A flush pulse arriving this cycle counts as pending so it beats a same-cycle request
   assign flush_req = flush_pend | bus.i_IC_Flush;
   assign hit       = valid[idx_q] && (rd_tag == tag_q);
   assign last_beat = (beat == WSEL_W'(WORDS - 1));
   assign beat_done = (state == IC_REFILL) && bus.i_MEM_Ready;

   // Arrays are read with the live address in IDLE, otherwise with the captured one
   assign rd_idx  = (state == IC_IDLE) ? req_idx  : idx_q;
   assign rd_word = (state == IC_IDLE) ? req_wsel : wsel_q;

   icache_mem #(
      .LINES  (LINES),
      .WORDS  (WORDS),
      .TAG_W  (TAG_W),
      .DATA_W (XLEN)
   ) u_mem (
      .i_clk   (i_clk),
      .rd_idx  (rd_idx),
      .rd_word (rd_word),
      .rd_tag  (rd_tag),
      .rd_data (rd_data),
      .data_we (beat_done),
      .wr_idx  (idx_q),
      .wr_word (beat),
      .wr_data (bus.i_MEM_Data),
      .tag_we  (beat_done && last_beat),
      .wr_tag  (tag_q)
   );

   // Controller state register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= IC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-cycle strobes; flush wins over requests and over a hit
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      ready     = 1'b0;
      miss      = 1'b0;
      case (state)
         IC_IDLE: begin
            if (flush_req) begin
               state_nxt = IC_FLUSH;
            end else if (bus.i_IC_DataReq) begin
               capture   = 1'b1;
               state_nxt = IC_LOOKUP;
            end
         end
         IC_LOOKUP: begin
            if (flush_req) begin
               state_nxt = IC_FLUSH;
            end else if (hit) begin
               ready     = 1'b1;
               state_nxt = IC_IDLE;
            end else begin
               miss      = 1'b1;
               state_nxt = IC_REFILL;
            end
         end
         IC_REFILL: begin
            if (bus.i_MEM_Ready && last_beat) begin
               state_nxt = IC_LOOKUP;
            end
         end
         IC_FLUSH: begin
            state_nxt = IC_IDLE;
         end
         default: begin
            state_nxt = IC_IDLE;
         end
      endcase
   end

   assign bus.o_IC_MemReady = ready;
   assign bus.o_IC_Instr    = ready ? rd_data : '0;
   assign bus.o_MEM_Req     = (state == IC_REFILL);
   assign bus.o_MEM_Addr    = (state == IC_REFILL)
                              ? {tag_q, idx_q, beat, {IC_BYTE_W{1'b0}}} : '0;

   // Hold the fetch address fields for the lookup and refill that follow
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         tag_q  <= '0;
         idx_q  <= '0;
         wsel_q <= '0;
      end else if (capture) begin
         tag_q  <= req_tag;
         idx_q  <= req_idx;
         wsel_q <= req_wsel;
      end
   end

   // Refill beat counter, restarted on every miss and wrapping naturally at WORDS
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         beat <= '0;
      end else if (miss) begin
         beat <= '0;
      end else if (beat_done) begin
         beat <= beat + WSEL_W'(1);
      end
   end

   // Line valid bits: dropped on miss so a partial refill is never seen, set on the last beat
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         valid <= '0;
      end else if (state == IC_FLUSH) begin
         valid <= '0;
      end else begin
         if (miss) begin
            valid[idx_q] <= 1'b0;
         end
         if (beat_done && last_beat) begin
            valid[idx_q] <= 1'b1;
         end
      end
   end

   // Remember a flush until the controller reaches a state where it can run it
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         flush_pend <= 1'b0;
      end else if (bus.i_IC_Flush) begin
         flush_pend <= 1'b1;
      end else if (state == IC_FLUSH) begin
         flush_pend <= 1'b0;
      end
   end

`ifdef ARVI_IC_STATS_EN
   // Hit and miss counters; a lookup lost to a flush raises neither strobe
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_IC_Hits   <= '0;
         o_IC_Misses <= '0;
      end else begin
         if (ready) begin
            o_IC_Hits <= o_IC_Hits + 32'd1;
         end
         if (miss) begin
            o_IC_Misses <= o_IC_Misses + 32'd1;
         end
      end
   end
`endif

endmodule
